// File: rtl/stream_demux_1ton_if.sv
// Bundle for stream_demux_1ton: one upstream valid/ready stream plus NUM_CH downstream channels.
// DEMUX_DROP_CNT_EN adds the drop_cnt observation signal.
interface stream_demux_1ton_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     sel_err;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]               drop_cnt;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, sel_err, drop_cnt
    );
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, sel_err, drop_cnt
    );
`else
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );
`endif
endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-NUM_CH stream demux with per-channel one-entry slots and broadcast mode.
// Optional macro DEMUX_DROP_CNT_EN adds a saturating 8-bit count of dropped out-of-range beats.
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input logic             clk,
    input logic             rst,
    stream_demux_1ton_if.slave bus
);
    // Handshake: a beat moves when in_valid & in_ready at a rising edge; in_ready never
    // looks at in_valid, and a channel beat is consumed when out_valid[k] & out_ready[k].

    logic [NUM_CH-1:0]        free;
    logic [NUM_CH-1:0]        load;
    logic [NUM_CH-1:0]        valid_q, valid_d;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic [31:0]              sel_wide;
    logic                     sel_ok;
    logic                     sel_free;
    logic                     ready;
    logic                     fire;
    logic                     drop;

    assign sel_wide = 32'(bus.in_sel);
    assign sel_ok   = (sel_wide < 32'(NUM_CH));
    assign free     = ~valid_q | bus.out_ready;

    always_comb begin
        sel_free = 1'b0;
        ready    = 1'b1;
        load     = '0;
        data_d   = data_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_wide == 32'(k)) sel_free = free[k];
        end
        // Out-of-range unicast stays ready so the bad beat is swallowed instead of stalling.
        if (bus.in_bcast)  ready = &free;
        else if (sel_ok)   ready = sel_free;
        fire = bus.in_valid & ready;
        drop = fire & ~bus.in_bcast & ~sel_ok;
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = fire & (bus.in_bcast | (sel_wide == 32'(k)));
            if (load[k]) data_d[k*DATA_W +: DATA_W] = bus.in_data;
        end
        valid_d = load | (valid_q & ~bus.out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= 8'd0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_cnt = drop_cnt_q;
    assign bus.sel_err  = (drop_cnt_q != 8'd0);
`else
    logic sel_err_q, sel_err_d;

    assign sel_err_d = sel_err_q | drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_err_q <= 1'b0;
        else     sel_err_q <= sel_err_d;
    end

    assign bus.sel_err = sel_err_q;
`endif
endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1ton

Overview:
- Parametrised, registered successor to the 1-to-4 demux.
- Routes one valid/ready input stream to one of NUM_CH output channels by a per-beat select, or to all channels in broadcast mode.
- Each channel has a one-entry holding register, so back-pressure on one channel never corrupts another.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 8, payload width in bits.
- NUM_CH, 4, number of output channels, at least 2.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  DATA_W  input payload.
- in_sel  in  SEL_W  destination channel index.
- in_bcast  in  1  1 = copy the beat to all channels; in_sel is ignored.
- out_valid  out  NUM_CH  per-channel valid.
- out_ready  in  NUM_CH  per-channel consumer ready.
- out_data  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- sel_err  out  1  sticky flag: a beat with an out-of-range select was dropped.

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 0, out_data = 0, sel_err = 0.
  - Any held beats are discarded.
- Per-channel slot k is free when !out_valid[k] | out_ready[k], i.e. a pop and refill can happen in the same cycle.
- in_ready is combinational and depends on in_sel and in_bcast:
  - Unicast, in_sel < NUM_CH: in_ready = free[in_sel].
  - Unicast, in_sel >= NUM_CH: in_ready = 1; the beat is dropped and sel_err is set at the next edge.
  - Broadcast: in_ready = AND of free[k] over all k. All-or-nothing; no partial broadcast.
- Transfer: occurs on in_valid & in_ready.
  - The target slot(s) load in_data and set out_valid at the next rising edge.
  - Latency from input handshake to out_valid is 1 cycle.
- Output pop: out_valid[k] & out_ready[k] clears out_valid[k] unless the same edge loads a new beat into slot k.
- out_data[k] holds its value while out_valid[k] = 0. Its value is don't-care to consumers in that state, but it must not change except on a load.
- Simultaneous pop on channel j and load on channel i != j: both take effect. There is no cross-channel coupling.
- in_valid = 0: no state change, regardless of the sel and bcast inputs.
- sel_err clears only on reset.
- Reset asserted mid-stream drops all held beats. No beat is emitted after reset release until a new input transfer occurs.
- in_ready must never depend on in_valid, so there is no combinational loop with upstream logic.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 8 bits, reset 0.
  - Increments on each dropped out-of-range beat and saturates at 255.
  - sel_err = (drop_cnt != 0).
- Undefined:
  - No drop_cnt port.
  - sel_err is a single sticky flop as described above.

Test Plan:
- Unicast routing (NUM_CH=4, DATA_W=8, all out_ready=1):
  - Stimulus: send 0x11 sel 0, 0x22 sel 1, 0x33 sel 2, 0x44 sel 3 on consecutive cycles.
  - Response: each appears on its channel exactly 1 cycle after acceptance; in_ready stays 1 throughout.
- Back-pressure isolation:
  - Stimulus: hold out_ready[2]=0; send 0xA0 then 0xA1 to sel 2, then 0xB0 to sel 1.
  - Response: 0xA0 is held on ch2; in_ready=0 while 0xA1 is presented; after the source switches to 0xB0 sel 1, 0xB0 is accepted and appears on ch1.
- Broadcast:
  - Stimulus: in_bcast=1 with data 0x5A while out_ready[3]=0 and ch3 is already full; release out_ready[3] after 2 cycles.
  - Response: in_ready=0 for 2 cycles; then all 4 channels show 0x5A on the same cycle.
- Pop/refill same cycle:
  - Stimulus: ch0 holds 0x01 with out_ready[0]=1; present 0x02 sel 0.
  - Response: 0x01 is consumed, 0x02 is valid the next cycle, and out_valid[0] never drops.
- Invalid select (NUM_CH=3, SEL_W=2):
  - Stimulus: send sel 3, data 0xFF.
  - Response: in_ready=1, no out_valid asserts, sel_err=1 next cycle; with DEMUX_DROP_CNT_EN, drop_cnt=1, and after 300 such beats drop_cnt=255.
- Async reset:
  - Stimulus: assert rst mid-cycle while channels 0 and 1 hold data.
  - Response: out_valid=0 immediately without waiting for a clock edge; sel_err=0; no stale beat appears after release.
